// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with a shared edge/center-aligned period counter.
// Debounced buttons adjust per-channel shadowed duties that load only at period boundaries.
module pwm_multi_channel #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned SEL_W        = 2,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned PERIOD       = 100,
    parameter int unsigned STEP         = 10,
    parameter int unsigned DUTY_INIT    = 50,
    parameter int unsigned DEBOUNCE_DIV = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                increase_duty,
    input  logic                decrease_duty,
    input  logic [SEL_W-1:0]    ch_sel,
    input  logic                align_mode,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CNT_W-1:0]    duty_sel,
    output logic                period_tick
);

    localparam int unsigned DIV_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;
    localparam int unsigned AW    = CNT_W + 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DEBOUNCE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] PERIOD_C  = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] INIT_C    = CNT_W'(DUTY_INIT);
    localparam logic [AW-1:0]    PERIOD_W  = AW'(PERIOD);
    localparam logic [AW-1:0]    STEP_W    = AW'(STEP);

    logic [DIV_W-1:0]    div_q, div_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                dir_q, dir_d;      // 1 = counting down
    logic                mode_q, mode_d;
    logic [CNT_W-1:0]    pend_q [CHANNELS];
    logic [CNT_W-1:0]    pend_d [CHANNELS];
    logic [CNT_W-1:0]    shad_q [CHANNELS];
    logic [CNT_W-1:0]    shad_d [CHANNELS];
    logic                inc_s1_q, inc_s1_d, inc_s2_q, inc_s2_d;
    logic                dec_s1_q, dec_s1_d, dec_s2_q, dec_s2_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                tick_q, tick_d;
    logic [CNT_W-1:0]    dsel_q, dsel_d;

    logic                tick_c, inc_ev_c, dec_ev_c, sel_ok_c, update_c;
    logic                bnd_c, next_bnd_c;
    logic [AW-1:0]       sel_val_c, sum_c;
    logic [CNT_W-1:0]    new_duty_c;

    // Debounce sample tick and single-cycle press events
    always_comb begin
        tick_c   = ena & (div_q == DIV_LAST);
        inc_ev_c = tick_c & inc_s1_q & ~inc_s2_q;
        dec_ev_c = tick_c & dec_s1_q & ~dec_s2_q;
        sel_ok_c = 32'(ch_sel) < CHANNELS;
        update_c = ena & sel_ok_c & (inc_ev_c ^ dec_ev_c);
    end

    // Saturating duty arithmetic, one bit wider than the duty so it never wraps
    always_comb begin
        sel_val_c = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (32'(ch_sel) == i) sel_val_c = {1'b0, pend_q[i]};
        end
        sum_c = sel_val_c + STEP_W;
        if (inc_ev_c) new_duty_c = (sum_c > PERIOD_W) ? PERIOD_C : sum_c[CNT_W-1:0];
        else          new_duty_c = (sel_val_c < STEP_W) ? '0 : CNT_W'(sel_val_c - STEP_W);
    end

    always_comb begin
        div_d      = div_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        mode_d     = mode_q;
        shad_d     = shad_q;
        pend_d     = pend_q;
        inc_s1_d   = inc_s1_q;
        inc_s2_d   = inc_s2_q;
        dec_s1_d   = dec_s1_q;
        dec_s2_d   = dec_s2_q;
        pwm_d      = '0;
        tick_d     = 1'b0;
        dsel_d     = '0;
        bnd_c      = mode_q ? ((cnt_q == '0) && dir_q) : (cnt_q == CNT_LAST);
        next_bnd_c = 1'b0;

        if (ena) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            if (tick_c) begin
                inc_s1_d = increase_duty;
                inc_s2_d = inc_s1_q;
                dec_s1_d = decrease_duty;
                dec_s2_d = dec_s1_q;
            end
            for (int unsigned i = 0; i < CHANNELS; i++) pwm_d[i] = cnt_q < shad_q[i];
            // Both modes restart at (0, up) after a boundary, so a mode switch needs no extra case
            if (bnd_c) begin
                cnt_d  = '0;
                dir_d  = 1'b0;
                mode_d = align_mode;
                shad_d = pend_q;
            end else if (!mode_q || !dir_q) begin
                if (mode_q && (cnt_q == CNT_LAST)) dir_d = 1'b1;
                else                               cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (update_c && (32'(ch_sel) == i)) pend_d[i] = new_duty_c;
        end
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (32'(ch_sel) == i) dsel_d = pend_d[i];
        end

        // Registered tick must line up with the boundary state it announces
        next_bnd_c = mode_d ? ((cnt_d == '0) && dir_d) : (cnt_d == CNT_LAST);
        if (ena) tick_d = next_bnd_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            mode_q   <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                pend_q[i] <= INIT_C;
                shad_q[i] <= INIT_C;
            end
            inc_s1_q <= 1'b0;
            inc_s2_q <= 1'b0;
            dec_s1_q <= 1'b0;
            dec_s2_q <= 1'b0;
            pwm_q    <= '0;
            tick_q   <= 1'b0;
            dsel_q   <= '0;
        end else begin
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            shad_q   <= shad_d;
            inc_s1_q <= inc_s1_d;
            inc_s2_q <= inc_s2_d;
            dec_s1_q <= dec_s1_d;
            dec_s2_q <= dec_s2_d;
            pwm_q    <= pwm_d;
            tick_q   <= tick_d;
            dsel_q   <= dsel_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign period_tick = tick_q;
    assign duty_sel    = dsel_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: phase-based behavioural model checked every cycle,
// plus directed windows with hand-computed high-time and tick counts.
module tb_pwm_multi_channel;

    localparam int CH = 3;
    localparam int SW = 2;
    localparam int CW = 8;
    localparam int P  = 100;
    localparam int ST = 10;
    localparam int DI = 50;
    localparam int DD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic          inc = 1'b0;
    logic          dec = 1'b0;
    logic [SW-1:0] sel = '0;
    logic          align = 1'b0;
    logic [CH-1:0] pwm_out;
    logic [CW-1:0] duty_sel;
    logic          period_tick;

    pwm_multi_channel #(
        .CHANNELS(CH), .SEL_W(SW), .CNT_W(CW), .PERIOD(P),
        .STEP(ST), .DUTY_INIT(DI), .DEBOUNCE_DIV(DD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .increase_duty(inc), .decrease_duty(dec), .ch_sel(sel),
        .align_mode(align), .pwm_out(pwm_out), .duty_sel(duty_sel),
        .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Model: position within the period as a phase index, duties as plain ints
    int m_phase, m_mode, m_div;
    int m_pend [CH];
    int m_shad [CH];
    int m_i1, m_i2, m_d1, m_d2;
    int e_pwm, e_tick, e_dsel;
    int hc [CH];
    int tc;

    function automatic void chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_phase = 0; m_mode = 0; m_div = 0;
        for (int i = 0; i < CH; i++) begin
            m_pend[i] = DI;
            m_shad[i] = DI;
        end
        m_i1 = 0; m_i2 = 0; m_d1 = 0; m_d2 = 0;
        e_pwm = 0; e_tick = 0; e_dsel = 0;
    endfunction

    function automatic void model_edge();
        int plen, cnt, tk, ei, ed, sok, s;
        if (!rst_n) return;
        sok = (int'(sel) < CH) ? 1 : 0;
        s   = int'(sel);
        if (ena) begin
            tk   = (m_div == DD - 1) ? 1 : 0;
            ei   = tk & m_i1 & (1 - m_i2);
            ed   = tk & m_d1 & (1 - m_d2);
            plen = m_mode ? 2 * P : P;
            cnt  = (m_phase < P) ? m_phase : 2 * P - 1 - m_phase;
            e_pwm = 0;
            for (int i = 0; i < CH; i++) if (cnt < m_shad[i]) e_pwm += (1 << i);
            if (m_phase == plen - 1) begin
                for (int i = 0; i < CH; i++) m_shad[i] = m_pend[i];
                m_mode  = int'(align);
                m_phase = 0;
            end else begin
                m_phase++;
            end
            if (tk) begin
                m_i2 = m_i1; m_i1 = int'(inc);
                m_d2 = m_d1; m_d1 = int'(dec);
            end
            m_div = (m_div + 1) % DD;
            if (sok && (ei != ed)) begin
                if (ei) m_pend[s] = (m_pend[s] + ST > P) ? P : m_pend[s] + ST;
                else    m_pend[s] = (m_pend[s] < ST) ? 0 : m_pend[s] - ST;
            end
            plen   = m_mode ? 2 * P : P;
            e_tick = (m_phase == plen - 1) ? 1 : 0;
        end else begin
            e_pwm  = 0;
            e_tick = 0;
        end
        e_dsel = sok ? m_pend[s] : 0;
    endfunction

    task automatic compare();
        chk("pwm_out", 32'(pwm_out), e_pwm);
        chk("period_tick", 32'(period_tick), e_tick);
        chk("duty_sel", 32'(duty_sel), e_dsel);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic run(int n);
        repeat (n) cycle();
    endtask

    task automatic window(int n);
        for (int i = 0; i < CH; i++) hc[i] = 0;
        tc = 0;
        repeat (n) begin
            cycle();
            for (int i = 0; i < CH; i++) hc[i] += 32'(pwm_out[i]);
            tc += 32'(period_tick);
        end
    endtask

    task automatic press(logic a, logic b);
        inc = a; dec = b;
        run(12);
        inc = 1'b0; dec = 1'b0;
        run(12);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("reset_pwm", 32'(pwm_out), 0);
        chk("reset_tick", 32'(period_tick), 0);
        chk("reset_dsel", 32'(duty_sel), 0);
        run(3);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        ena = 1'b1; align = 1'b0; sel = 2'd0;
        do_reset();

        // Defaults: 50 of 100 high on every channel, one tick per 100
        run(150);
        window(100);
        for (int i = 0; i < CH; i++) chk("default_high", hc[i], 50);
        chk("edge_ticks", tc, 1);

        // Single press on ch2
        sel = 2'd2;
        press(1'b1, 1'b0);
        chk("ch2_dsel60", 32'(duty_sel), 60);
        run(250);
        window(100);
        chk("ch2_high60", hc[2], 60);
        chk("ch0_high50", hc[0], 50);
        chk("ch1_high50", hc[1], 50);

        // Mid-period press on ch0
        sel = 2'd0;
        run(17);
        press(1'b1, 1'b0);
        chk("ch0_dsel60", 32'(duty_sel), 60);

        // Saturation on ch1
        sel = 2'd1;
        repeat (6) press(1'b1, 1'b0);
        chk("ch1_sat_hi", 32'(duty_sel), 100);
        run(250);
        window(100);
        chk("ch1_const_hi", hc[1], 100);
        repeat (11) press(1'b0, 1'b1);
        chk("ch1_sat_lo", 32'(duty_sel), 0);
        run(250);
        window(100);
        chk("ch1_const_lo", hc[1], 0);

        // Simultaneous inc/dec leaves duty alone
        sel = 2'd0;
        press(1'b1, 1'b1);
        chk("incdec_same", 32'(duty_sel), 60);

        // Out-of-range channel
        sel = 2'd3;
        press(1'b1, 1'b0);
        chk("sel3_dsel0", 32'(duty_sel), 0);

        // Center-aligned mode, switched mid-period
        run(33);
        align = 1'b1;
        run(450);
        window(200);
        chk("ctr_ch0_120", hc[0], 120);
        chk("ctr_ch2_120", hc[2], 120);
        chk("ctr_ch1_0", hc[1], 0);
        chk("ctr_ticks", tc, 1);

        // Enable low for 37 cycles
        run(41);
        ena = 1'b0;
        run(37);
        chk("ena_off_pwm", 32'(pwm_out), 0);
        ena = 1'b1;
        run(60);

        // Async reset mid-period returns to edge mode and DUTY_INIT
        align = 1'b0;
        sel = 2'd0;
        @(posedge clk);
        model_edge();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_pwm0", 32'(pwm_out), 0);
        @(negedge clk);
        compare();
        run(2);
        rst_n = 1'b1;
        cycle();
        chk("post_rst_dsel", 32'(duty_sel), 50);
        run(150);
        window(100);
        for (int i = 0; i < CH; i++) chk("post_rst_high", hc[i], 50);
        chk("post_rst_ticks", tc, 1);

        // Randomized traffic against the model
        for (int n = 0; n < 15000; n++) begin
            if ($urandom_range(15) == 0) inc = ~inc;
            if ($urandom_range(15) == 0) dec = ~dec;
            if ($urandom_range(63) == 0) sel = SW'($urandom_range(3));
            if ($urandom_range(299) == 0) align = ~align;
            if (ena) begin
                if ($urandom_range(199) == 0) ena = 1'b0;
            end else if ($urandom_range(7) == 0) begin
                ena = 1'b1;
            end
            if ($urandom_range(2999) == 0) begin
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
